fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the program counter.
- Takes the PC value each cycle and issues in-order read requests to instruction memory over a req/gnt plus rvalid handshake.
- Buffers returned instructions, each with its PC, in a small FIFO and presents them to decode with valid/ready.
- Back-pressures the PC via pc_stall; discards all buffered and in-flight work on flush (taken branch).

---
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage between the program counter and decode.
// Issues in-order requests to instruction memory under a credit limit, pairs
// each response with its PC through a tag FIFO, buffers results for decode,
// and discards queued and in-flight work on a taken-branch flush.
module fetch_queue #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    input  logic              flush,
    output logic              pc_stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state, state_n;
    logic [CW-1:0] inflight, inflight_n;
    logic [CW-1:0] discard, discard_n;
    logic          req_n;

    // Tag FIFO: address of every granted, still-wanted request, in order.
    logic [ADDR_W-1:0] tag_mem [DEPTH];
    logic [PW-1:0]     tag_wptr, tag_rptr;
    logic [ADDR_W-1:0] tag_head;

    // Instruction FIFO presented to decode.
    logic [DATA_W-1:0] dat_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem  [DEPTH];
    logic [PW-1:0]     fifo_wptr, fifo_rptr;
    logic [CW-1:0]     fifo_count;

    logic gnt_fire, credit, accept, push, pop, tag_push;

    assign gnt_fire = imem_req & imem_gnt;
    // Every granted request must own a FIFO slot before it is issued.
    assign credit   = ({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_V;
    assign accept   = (state == S_IDLE) & pc_valid & credit & ~flush;
    // A response is kept only if nothing older than it was flushed.
    assign push     = imem_rvalid & ~flush & (discard == '0);
    assign pop      = instr_valid & instr_ready & ~flush;
    assign tag_push = gnt_fire & ~flush & (state != S_DRAIN);
    assign tag_head = tag_mem[tag_rptr];

    assign pc_stall = reset & ((state != S_IDLE) | (pc_valid & ~accept));

    assign instr_valid    = (fifo_count != '0);
    assign instr          = instr_valid ? dat_mem[fifo_rptr] : '0;
    assign instr_pc       = instr_valid ? pc_mem[fifo_rptr]  : '0;
    assign instr_misalign = (instr_pc[1:0] != 2'b00);

    // Next-state for the request FSM and the outstanding/discard counters.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_n    = state;
        req_n      = imem_req;
        inflight_n = inflight + CW'(gnt_fire) - CW'(imem_rvalid);
        discard_n  = discard;

        if (accept)
            req_n = 1'b1;
        else if (gnt_fire)
            req_n = 1'b0;

        if (flush) begin
            // Everything still in flight after this edge (including a grant
            // landing now) belongs to the wrong path.
            discard_n = inflight_n;
        end else begin
            discard_n = discard
                        + CW'(gnt_fire && (state == S_DRAIN))
                        - CW'(imem_rvalid && (discard != '0));
        end

        if (flush || (state == S_DRAIN)) begin
            state_n = ((discard_n != '0) || req_n) ? S_DRAIN : S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept)   state_n = S_REQ;
                S_REQ:   if (gnt_fire) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Control state, request port and FIFO pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state      <= S_IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            inflight   <= '0;
            discard    <= '0;
            tag_wptr   <= '0;
            tag_rptr   <= '0;
            fifo_wptr  <= '0;
            fifo_rptr  <= '0;
            fifo_count <= '0;
        end else begin
            state    <= state_n;
            imem_req <= req_n;
            inflight <= inflight_n;
            discard  <= discard_n;
            if (accept)
                imem_addr <= pc_in;

            if (flush) begin
                tag_wptr   <= '0;
                tag_rptr   <= '0;
                fifo_wptr  <= '0;
                fifo_rptr  <= '0;
                fifo_count <= '0;
            end else begin
                if (tag_push) tag_wptr  <= tag_wptr + PW'(1);
                if (push)     tag_rptr  <= tag_rptr + PW'(1);
                if (push)     fifo_wptr <= fifo_wptr + PW'(1);
                if (pop)      fifo_rptr <= fifo_rptr + PW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays for tags and buffered instructions.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; outputs are masked by instr_valid and reads follow writes.
        if (tag_push)
            tag_mem[tag_wptr] <= imem_addr;
        if (push) begin
            dat_mem[fifo_wptr] <= imem_rdata;
            pc_mem[fifo_wptr]  <= tag_head;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus for fetch_queue with a transaction-level
// model (pending request, in-flight list, output queue) compared every cycle,
// plus hand-computed literal expectations at key points.
module tb_fetch_queue;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              flush;
    logic              pc_stall;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_misalign;

    always #5 clk = ~clk;

    fetch_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .flush(flush),
        .pc_stall(pc_stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_misalign(instr_misalign)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- transaction model ----------------
    typedef struct packed { logic [ADDR_W-1:0] pc; logic drop; } flight_t;
    typedef struct packed { logic [DATA_W-1:0] data; logic [ADDR_W-1:0] pc; } entry_t;

    flight_t infl_q[$];
    entry_t  out_q[$];
    bit      pend_v = 0;
    flight_t pend;

    bit              s_reset = 0, s_pc_valid = 0, s_flush = 0, s_gnt = 0, s_rvalid = 0, s_ready = 0;
    logic [ADDR_W-1:0] s_pc_in = '0;
    logic [DATA_W-1:0] s_rdata = '0;

    function automatic bit m_draining();
        if (pend_v && pend.drop) return 1'b1;
        foreach (infl_q[i]) if (infl_q[i].drop) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_credit();
        return (out_q.size() + infl_q.size()) < DEPTH;
    endfunction

    // Compare DUT outputs against the model mid-cycle, then snapshot inputs.
    always @(negedge clk) begin
        bit     exp_stall;
        entry_t head;
        if (!reset) begin
            check("rst_imem_req", imem_req, 0);
            check("rst_instr_valid", instr_valid, 0);
            check("rst_pc_stall", pc_stall, 0);
        end else begin
            exp_stall = (pend_v || m_draining()) ? 1'b1 : (pc_valid && !(m_credit() && !flush));
            check("pc_stall", pc_stall, exp_stall);
            check("imem_req", imem_req, pend_v);
            if (pend_v) check("imem_addr", imem_addr, pend.pc);
            check("instr_valid", instr_valid, out_q.size() != 0);
            if (out_q.size() != 0) begin
                head = out_q[0];
                check("instr", instr, head.data);
                check("instr_pc", instr_pc, head.pc);
                check("instr_misalign", instr_misalign, head.pc[1:0] != 2'b00);
            end
        end
        s_reset = reset; s_pc_valid = pc_valid; s_pc_in = pc_in; s_flush = flush;
        s_gnt = imem_gnt; s_rvalid = imem_rvalid; s_rdata = imem_rdata; s_ready = instr_ready;
    end

    // Advance the model by one clock edge from the snapshot.
    always @(posedge clk) begin
        bit      do_accept, do_pop;
        flight_t f;
        entry_t  e;
        if (!s_reset) begin
            infl_q.delete();
            out_q.delete();
            pend_v = 0;
        end else begin
            do_accept = s_pc_valid && !pend_v && !m_draining() && m_credit() && !s_flush;
            do_pop    = (out_q.size() != 0) && s_ready && !s_flush;
            if (do_pop) void'(out_q.pop_front());
            if (s_rvalid) begin
                check("rvalid_has_request", infl_q.size() != 0, 1);
                if (infl_q.size() != 0) begin
                    f = infl_q.pop_front();
                    if (!f.drop && !s_flush) begin
                        e.data = s_rdata;
                        e.pc   = f.pc;
                        out_q.push_back(e);
                    end
                end
            end
            if (pend_v && s_gnt) begin
                f = pend;
                f.drop = f.drop | s_flush;
                infl_q.push_back(f);
                pend_v = 0;
            end
            if (s_flush) begin
                out_q.delete();
                foreach (infl_q[i]) infl_q[i].drop = 1'b1;
                if (pend_v) pend.drop = 1'b1;
            end
            if (do_accept) begin
                pend.pc   = s_pc_in;
                pend.drop = 1'b0;
                pend_v    = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit pv, input logic [ADDR_W-1:0] pc, input bit fl, input bit g,
                         input bit rv, input logic [DATA_W-1:0] rd, input bit rdy);
        pc_valid = pv; pc_in = pc; flush = fl; imem_gnt = g;
        imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit pv, input logic [ADDR_W-1:0] pc, input bit fl, input bit g,
                        input bit rv, input logic [DATA_W-1:0] rd, input bit rdy);
        drive(pv, pc, fl, g, rv, rd, rdy);
        tick();
    endtask

    // Accept one PC, grant after gnt_delay idle REQ cycles, return data next cycle.
    task automatic fetch(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] data,
                         input int gnt_delay, input bit rdy_on_rvalid);
        step(1, pc, 0, 0, 0, 0, 0);
        repeat (gnt_delay) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, data, rdy_on_rvalid);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        drive(1, 16'h1234, 0, 0, 0, 0, 0);
        #3;
        check("reset_imem_req", imem_req, 0);
        check("reset_imem_addr", imem_addr, 0);
        check("reset_instr_valid", instr_valid, 0);
        check("reset_instr", instr, 0);
        check("reset_instr_pc", instr_pc, 0);
        check("reset_misalign", instr_misalign, 0);
        check("reset_pc_stall", pc_stall, 0);
        tick();
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);

        // 1. single fetch, grant after 2 REQ cycles
        step(1, 16'h0000, 0, 0, 0, 0, 0);
        check("t1_req", imem_req, 1);
        check("t1_addr", imem_addr, 16'h0000);
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        check("t1_stall_in_req", pc_stall, 1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t1_req_dropped", imem_req, 0);
        check("t1_stall_after_gnt", pc_stall, 0);
        step(0, 0, 0, 0, 1, 32'h00A00093, 0);
        check("t1_valid", instr_valid, 1);
        check("t1_instr", instr, 32'h00A00093);
        check("t1_pc", instr_pc, 16'h0000);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t1_empty", instr_valid, 0);

        // 2. fill to DEPTH, back-pressure the fifth PC, one pop releases it
        for (int i = 0; i < 4; i++) fetch(16'(4*i), 32'h1000_0000 + 32'(4*i), 0, 0);
        drive(1, 16'h0010, 0, 0, 0, 0, 0); #1;
        check("t2_stall_full", pc_stall, 1);
        check("t2_head_pc", instr_pc, 16'h0000);
        tick();
        drive(1, 16'h0010, 0, 0, 0, 0, 1); #1;
        check("t2_stall_full_pop", pc_stall, 1);
        tick();
        drive(1, 16'h0010, 0, 0, 0, 0, 0); #1;
        check("t2_stall_released", pc_stall, 0);
        tick();
        check("t2_req_addr", imem_addr, 16'h0010);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h1000_0010, 0);
        for (int k = 0; k < 4; k++) begin
            check("t2_order", instr_pc, 16'(4 + 4*k));
            step(0, 0, 0, 0, 0, 0, 1);
        end
        check("t2_drained", instr_valid, 0);

        // 3. flush with one buffered entry and two requests in flight
        fetch(16'h001C, 32'h0000_001C, 0, 0);
        step(1, 16'h0020, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 16'h0024, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t3_buffered", instr_valid, 1);
        step(0, 0, 1, 0, 0, 0, 1);
        check("t3_flushed", instr_valid, 0);
        check("t3_drain_stall", pc_stall, 1);
        step(0, 0, 0, 0, 1, 32'h0000_DEAD, 0);
        check("t3_dead_dropped", instr_valid, 0);
        check("t3_still_draining", pc_stall, 1);
        step(0, 0, 0, 0, 1, 32'h0000_BEEF, 0);
        check("t3_beef_dropped", instr_valid, 0);
        drive(1, 16'h0040, 0, 0, 0, 0, 0); #1;
        check("t3_drain_done", pc_stall, 0);
        tick();
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0400_0413, 0);
        check("t3_new_valid", instr_valid, 1);
        check("t3_new_pc", instr_pc, 16'h0040);
        check("t3_new_instr", instr, 32'h0400_0413);
        step(0, 0, 0, 0, 0, 0, 1);

        // 4. flush coincident with a response and a pending request
        step(1, 16'h0080, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 16'h0084, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 32'h1111_1111, 0);
        check("t4_req_held", imem_req, 1);
        check("t4_addr_held", imem_addr, 16'h0084);
        check("t4_no_valid", instr_valid, 0);
        check("t4_stall", pc_stall, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t4_req_granted", imem_req, 0);
        check("t4_stall_drain", pc_stall, 1);
        step(0, 0, 0, 0, 1, 32'h2222_2222, 0);
        check("t4_dropped", instr_valid, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t4_no_stale", instr_valid, 0);
        drive(1, 16'h0088, 0, 0, 0, 0, 0); #1;
        check("t4_idle_again", pc_stall, 0);
        tick();
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0880_0088, 0);
        check("t4_new_pc", instr_pc, 16'h0088);
        step(0, 0, 0, 0, 0, 0, 1);

        // 5. push and pop together with two entries buffered
        fetch(16'h0000, 32'h5000_0000, 0, 0);
        fetch(16'h0004, 32'h5000_0004, 0, 0);
        for (int k = 2; k < 12; k++) begin
            fetch(16'(4*k), 32'h5000_0000 + 32'(4*k), 0, 1);
            check("t5_valid", instr_valid, 1);
            check("t5_head", instr_pc, 16'(4*(k-1)));
        end
        check("t5_tail0", instr_pc, 16'h0028);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t5_tail1", instr_pc, 16'h002C);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t5_count2", instr_valid, 0);

        // 6. async reset mid-REQ, then a misaligned fetch
        fetch(16'h00FC, 32'h0FC0_0000, 0, 0);
        step(1, 16'h0100, 0, 0, 0, 0, 0);
        check("t6_in_req", imem_req, 1);
        drive(1, 16'h0104, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_req", imem_req, 0);
        check("t6_rst_valid", instr_valid, 0);
        check("t6_rst_stall", pc_stall, 0);
        check("t6_rst_addr", imem_addr, 0);
        check("t6_rst_instr", instr, 0);
        check("t6_rst_pc", instr_pc, 0);
        tick();
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0);
        fetch(16'h0006, 32'h0000_0013, 1, 0);
        check("t6_mis_valid", instr_valid, 1);
        check("t6_mis_flag", instr_misalign, 1);
        check("t6_mis_pc", instr_pc, 16'h0006);
        check("t6_mis_instr", instr, 32'h0000_0013);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t6_mis_cleared", instr_misalign, 0);

        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
